k503_sprite_sched: RTL and testbench
====================================

# k503_sprite_sched

Per-scanline sprite evaluation scheduler for the Konami 503 sprite-data chip. On each line start it walks the sprite attribute RAM one slot at a time. It presents each slot's Y byte to the 503 on OB and drives the 503's H4/H8/LD phase pins in a fixed sequence. It samples the 503's OCS hit flag and R row output, and for hits fetches the remaining attribute bytes and hands a sprite descriptor to the line-buffer writer over a valid/ready port. It sits between sprite RAM, the 503, and the sprite line-buffer logic.

## Interface
Parameters:
- NUM_SPR, 24: sprite slots scanned per line (1..64).
- MAX_HITS, 8: descriptors emitted per line before the scan stops with overflow.

Ports:
- Clock and reset: one clock; reset is synchronous and active-low.
  - CLK  in  1  system clock.
  - nRESET  in  1  synchronous, active-low reset.
- CEN  in  1  clock enable; all state advances only on CLK edges with CEN=1.
- LINE_START  in  1  one-CEN pulse; starts (or restarts) a scan.
- VCNT  in  8  vertical counter; forwarded to the 503, held by the system for the whole line.
- SPR_A  out  8  sprite RAM byte address = {slot, byte[1:0]}; byte 0=Y, 1=code, 2=attr, 3=X.
- SPR_D  in  8  sprite RAM data; valid one CEN after SPR_A changes.
- OB  out  8  to 503 OB.
- K_H4, K_H8, K_LD  out  1  to 503 H4, H8, LD.
- OCS  in  1  from 503; 0 means the slot covers this line.
- R  in  6  from 503 row output.
- HIT_VALID  out  1  descriptor valid.
- HIT_READY  in  1  consumer accepts.
- HIT_CODE, HIT_ATTR, HIT_X  out  8  descriptor bytes.
- HIT_ROW  out  6  R captured at the slot's evaluation.
- BUSY  out  1  scan in progress.
- OVERFLOW  out  1  sticky per line; set when a hit occurs with MAX_HITS already emitted.

## Operation
- States: IDLE, ADDR, YPH, DATPH, EVAL, F_CODE, F_ATTR, F_X, PUSH, NEXT. Each transition takes one CEN.
- IDLE: K_LD=1, K_H4=0, K_H8=0. LINE_START sets slot=0, hits=0, OVERFLOW=0, BUSY=1, and moves to ADDR.
- ADDR: SPR_A={slot,00}.
- YPH: OB<=SPR_D (Y), with K_LD=0, K_H4=0, K_H8=0.
- DATPH: K_H4=1, K_H8=0. This is the 503 ODAT-low window; the H4 rise latches OB[7:6].
- EVAL: K_H4=0, which ends ODAT and latches the 503. Capture OCS and R into registers. K_LD returns to 1 on leaving EVAL.
- Exit from EVAL:
  - OCS=1 → NEXT.
  - OCS=0 with hits==MAX_HITS → set OVERFLOW, go to IDLE, BUSY=0.
  - OCS=0 otherwise → F_CODE.
- F_CODE, F_ATTR, F_X: SPR_A = byte 1, 2, 3. Each byte is captured one CEN later, with F_X capture occurring in PUSH.
- PUSH: load the descriptor and set HIT_VALID=1 only if no descriptor is pending. Otherwise hold in PUSH. hits increments on load.
- Handshake: a transfer occurs on a CLK edge with HIT_VALID & HIT_READY. It is independent of CEN. Descriptor fields are stable while HIT_VALID=1. HIT_VALID clears on transfer unless a new descriptor loads on the same edge.
- NEXT: if slot==NUM_SPR-1, go to IDLE with BUSY=0. Otherwise slot+1 → ADDR.
- slot is a 6-bit counter; hits is 4-bit saturating at MAX_HITS.

## Timing
- Reset values: OB=0, SPR_A=0, K_LD=1, K_H4=0, K_H8=0, HIT_VALID=0, all HIT_* fields 0, BUSY=0, OVERFLOW=0, state IDLE.
- A miss costs 5 CEN (ADDR..NEXT minus the fetch states). A hit costs 9 CEN plus any PUSH stall.
- The first SPR_A for slot 0 appears one CEN after LINE_START.
- LINE_START while BUSY aborts the current scan and restarts at slot 0 on the same edge.
  - A pending HIT_VALID descriptor is kept until accepted.
  - hits and OVERFLOW reset.
- LINE_START together with a PUSH load: the restart wins and the load is dropped.
- nRESET low on any edge forces reset values regardless of CEN.
- K_H8 remains 0 throughout. The OCOL phase is owned by the line-buffer writer.

## Test plan
- Single hit: NUM_SPR=4, VCNT=0x20, slot 2 Y=0xD0 (sum 0xF0) and others Y=0x00, HIT_READY=1.
  - Required: exactly one descriptor with the slot-2 code/attr/X.
  - Required: BUSY falls 4×5+4 CEN after LINE_START.
- All miss: all slots miss → HIT_VALID never rises, OVERFLOW=0, BUSY high for NUM_SPR×5 CEN.
- Overflow: all 24 slots hit, MAX_HITS=8 → 8 descriptors, OVERFLOW=1 after the 9th hit, no 9th descriptor.
- Backpressure: HIT_READY=0 for 20 cycles after the first hit.
  - Required: PUSH stalls, fields stable, no descriptor lost, order preserved.
- Restart: LINE_START asserted at slot 5 → scan resumes at SPR_A=0x00 next CEN, OVERFLOW and hits cleared.
- Reset: nRESET low mid-fetch → next edge shows K_LD=1, HIT_VALID=0, BUSY=0, SPR_A=0.

Source files
------------

// File: rtl/k503_sprite_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : k503_sprite_sched_if
// Purpose  : Bundle of the sprite scheduler's RAM, 503 and descriptor signals.
// Revision : 1.0 - initial release
// ============================================================================
interface k503_sprite_sched_if;
  logic       CEN;
  logic       LINE_START;
  logic [7:0] VCNT;
  logic [7:0] SPR_A;
  logic [7:0] SPR_D;
  logic [7:0] OB;
  logic       K_H4;
  logic       K_H8;
  logic       K_LD;
  logic       OCS;
  logic [5:0] R;
  logic       HIT_VALID;
  logic       HIT_READY;
  logic [7:0] HIT_CODE;
  logic [7:0] HIT_ATTR;
  logic [7:0] HIT_X;
  logic [5:0] HIT_ROW;
  logic       BUSY;
  logic       OVERFLOW;

  modport master (
    input  CEN, LINE_START, VCNT, SPR_D, OCS, R, HIT_READY,
    output SPR_A, OB, K_H4, K_H8, K_LD, HIT_VALID, HIT_CODE, HIT_ATTR,
           HIT_X, HIT_ROW, BUSY, OVERFLOW
  );

  modport slave (
    output CEN, LINE_START, VCNT, SPR_D, OCS, R, HIT_READY,
    input  SPR_A, OB, K_H4, K_H8, K_LD, HIT_VALID, HIT_CODE, HIT_ATTR,
           HIT_X, HIT_ROW, BUSY, OVERFLOW
  );
endinterface
`default_nettype wire

// File: rtl/k503_sprite_sched.sv
`default_nettype none
// ============================================================================
// Module   : k503_sprite_sched
// Purpose  : Per-scanline sprite RAM walk driving the 503 and emitting hits.
// Revision : 1.0 - initial release
// ============================================================================
module k503_sprite_sched #(
  parameter int NUM_SPR  = 24,
  parameter int MAX_HITS = 8
) (
  input  logic                CLK,
  input  logic                nRESET,
  k503_sprite_sched_if.master bus
);

  localparam logic [5:0] c_last_slot = 6'(NUM_SPR - 1);
  localparam logic [3:0] c_max_hits  = 4'(MAX_HITS);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_ADDR   = 4'd1,
    S_YPH    = 4'd2,
    S_DATPH  = 4'd3,
    S_EVAL   = 4'd4,
    S_F_CODE = 4'd5,
    S_F_ATTR = 4'd6,
    S_F_X    = 4'd7,
    S_PUSH   = 4'd8,
    S_NEXT   = 4'd9
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [5:0] r_slot;
  logic [5:0] w_slot_nxt;
  logic [3:0] r_hits;
  logic       r_overflow;
  logic       w_set_ovf;
  logic [7:0] r_spr_a;
  logic [7:0] r_ob;
  logic [7:0] r_code;
  logic [7:0] r_attr;
  logic [5:0] r_row;
  logic       r_k_ld;
  logic       r_k_h4;
  logic       r_hit_valid;
  logic [7:0] r_hit_code;
  logic [7:0] r_hit_attr;
  logic [7:0] r_hit_x;
  logic [5:0] r_hit_row;
  logic       w_pending;
  logic       w_xfer;
  logic       w_load;
  logic       w_unused_vcnt;

  // A descriptor being accepted this edge frees the output slot for a new load.
  assign w_pending     = r_hit_valid & ~bus.HIT_READY;
  assign w_xfer        = r_hit_valid & bus.HIT_READY;
  assign w_load        = bus.CEN & ~bus.LINE_START & ~w_pending & (r_state == S_PUSH);
  assign w_unused_vcnt = ^bus.VCNT;

  always_ff @(posedge CLK) begin
    if (!nRESET) begin
      r_state <= S_IDLE;
    end else if (bus.CEN) begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_slot_nxt  = r_slot;
    w_set_ovf   = 1'b0;
    unique case (r_state)
      S_IDLE:   w_state_nxt = S_IDLE;
      S_ADDR:   w_state_nxt = S_YPH;
      S_YPH:    w_state_nxt = S_DATPH;
      S_DATPH:  w_state_nxt = S_EVAL;
      S_EVAL: begin
        if (bus.OCS) begin
          w_state_nxt = S_NEXT;
        end else if (r_hits == c_max_hits) begin
          w_state_nxt = S_IDLE;
          w_set_ovf   = 1'b1;
        end else begin
          w_state_nxt = S_F_CODE;
        end
      end
      S_F_CODE: w_state_nxt = S_F_ATTR;
      S_F_ATTR: w_state_nxt = S_F_X;
      S_F_X:    w_state_nxt = S_PUSH;
      S_PUSH:   if (!w_pending) w_state_nxt = S_NEXT;
      S_NEXT: begin
        if (r_slot == c_last_slot) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_ADDR;
          w_slot_nxt  = r_slot + 6'd1;
        end
      end
      default:  w_state_nxt = S_IDLE;
    endcase
    // A line start restarts the walk from any state, including mid-fetch.
    if (bus.LINE_START) begin
      w_state_nxt = S_ADDR;
      w_slot_nxt  = 6'd0;
      w_set_ovf   = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRESET) begin
      r_slot      <= 6'd0;
      r_hits      <= 4'd0;
      r_overflow  <= 1'b0;
      r_spr_a     <= 8'd0;
      r_ob        <= 8'd0;
      r_code      <= 8'd0;
      r_attr      <= 8'd0;
      r_row       <= 6'd0;
      r_k_ld      <= 1'b1;
      r_k_h4      <= 1'b0;
      r_hit_valid <= 1'b0;
      r_hit_code  <= 8'd0;
      r_hit_attr  <= 8'd0;
      r_hit_x     <= 8'd0;
      r_hit_row   <= 6'd0;
    end else begin
      if (bus.CEN) begin
        r_slot <= w_slot_nxt;
        r_k_ld <= !(w_state_nxt inside {S_YPH, S_DATPH, S_EVAL});
        r_k_h4 <= (w_state_nxt == S_DATPH);
        case (w_state_nxt)
          S_ADDR:   r_spr_a <= {w_slot_nxt, 2'b00};
          S_F_CODE: r_spr_a <= {w_slot_nxt, 2'b01};
          S_F_ATTR: r_spr_a <= {w_slot_nxt, 2'b10};
          S_F_X:    r_spr_a <= {w_slot_nxt, 2'b11};
          default:  ;
        endcase
        if (bus.LINE_START) begin
          r_hits     <= 4'd0;
          r_overflow <= 1'b0;
        end else begin
          // RAM data trails the address by one CEN, so each byte lands a state later.
          case (r_state)
            S_YPH:    r_ob <= bus.SPR_D;
            S_EVAL: begin
              r_row <= bus.R;
              if (w_set_ovf) r_overflow <= 1'b1;
            end
            S_F_ATTR: r_code <= bus.SPR_D;
            S_F_X:    r_attr <= bus.SPR_D;
            S_PUSH:   if (w_load && (r_hits != c_max_hits)) r_hits <= r_hits + 4'd1;
            default:  ;
          endcase
        end
      end
      if (w_load) begin
        r_hit_valid <= 1'b1;
        r_hit_code  <= r_code;
        r_hit_attr  <= r_attr;
        r_hit_x     <= bus.SPR_D;
        r_hit_row   <= r_row;
      end else if (w_xfer) begin
        r_hit_valid <= 1'b0;
      end
    end
  end

  assign bus.SPR_A     = r_spr_a;
  assign bus.OB        = r_ob;
  assign bus.K_LD      = r_k_ld;
  assign bus.K_H4      = r_k_h4;
  assign bus.K_H8      = 1'b0;
  assign bus.HIT_VALID = r_hit_valid;
  assign bus.HIT_CODE  = r_hit_code;
  assign bus.HIT_ATTR  = r_hit_attr;
  assign bus.HIT_X     = r_hit_x;
  assign bus.HIT_ROW   = r_hit_row;
  assign bus.BUSY      = (r_state != S_IDLE);
  assign bus.OVERFLOW  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_k503_sprite_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_k503_sprite_sched
// Purpose  : Scoreboard bench for k503_sprite_sched with RAM and 503 models.
// Revision : 1.0 - initial release
// ============================================================================
module tb_k503_sprite_sched;
  localparam int NSPR = 24;
  localparam int MAXH = 8;

  typedef struct packed {
    logic [7:0] code;
    logic [7:0] attr;
    logic [7:0] x;
    logic [5:0] row;
  } desc_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   cen_mode = 0;
  int   cen_cnt = 0;
  logic cen_seen = 1'b0;
  logic [7:0] mem [0:255];
  logic [7:0] sum;
  desc_t exp_q[$];

  always #5 clk = ~clk;

  k503_sprite_sched_if bus ();

  k503_sprite_sched #(.NUM_SPR(NSPR), .MAX_HITS(MAXH)) dut (
    .CLK    (clk),
    .nRESET (rst_n),
    .bus    (bus)
  );

  // 503 stand-in: the slot covers the line when Y+VCNT lands in 0xF0..0xFF.
  assign sum     = bus.OB + bus.VCNT;
  assign bus.OCS = (sum[7:4] != 4'hF);
  assign bus.R   = sum[5:0];

  initial forever begin
    @(posedge clk);
    if (bus.CEN) bus.SPR_D <= mem[bus.SPR_A];
  end

  initial forever begin
    @(posedge clk);
    cen_seen <= bus.CEN;
    if (bus.CEN) cen_cnt <= cen_cnt + 1;
  end

  initial begin
    bus.CEN = 1'b1;
    forever begin
      @(negedge clk);
      case (cen_mode)
        0:       bus.CEN = 1'b1;
        1:       bus.CEN = ~bus.CEN;
        default: bus.CEN = 1'b0;
      endcase
    end
  end

  // Monitor: pops on every accepted descriptor, checks hold while stalled.
  initial begin
    desc_t cur;
    desc_t prev_d;
    desc_t e;
    logic  prev_valid;
    logic  prev_ready;
    prev_valid = 1'b0;
    prev_ready = 1'b0;
    prev_d     = '0;
    forever begin
      @(negedge clk);
      cur = {bus.HIT_CODE, bus.HIT_ATTR, bus.HIT_X, bus.HIT_ROW};
      if (rst_n && prev_valid && !prev_ready) begin
        n_tests++;
        if (!bus.HIT_VALID || (cur != prev_d)) begin
          n_fail++;
          $display("FAIL hold: got valid=%0b desc=%h expected valid=1 desc=%h", bus.HIT_VALID, cur, prev_d);
        end
      end
      if (rst_n && bus.HIT_VALID && bus.HIT_READY) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_desc: got %h expected none", cur);
        end else begin
          e = exp_q.pop_front();
          if (cur !== e) begin
            n_fail++;
            $display("FAIL desc: got %h expected %h", cur, e);
          end
        end
      end
      prev_valid = bus.HIT_VALID;
      prev_ready = bus.HIT_READY;
      prev_d     = cur;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic desc_t slot_desc(input int s, input logic [5:0] row);
    desc_t d;
    d.code = 8'(8'h40 + s);
    d.attr = 8'(8'h80 + s);
    d.x    = 8'(s * 7 + 3);
    d.row  = row;
    return d;
  endfunction

  task automatic load_mem(input logic [63:0] hit_mask);
    for (int s = 0; s < 64; s++) begin
      mem[{s[5:0], 2'b00}] = hit_mask[s] ? 8'hD0 : 8'h00;
      mem[{s[5:0], 2'b01}] = 8'(8'h40 + s);
      mem[{s[5:0], 2'b10}] = 8'(8'h80 + s);
      mem[{s[5:0], 2'b11}] = 8'(s * 7 + 3);
    end
  endtask

  task automatic push_range(input int first, input int last, input logic [63:0] hit_mask, input logic [5:0] row);
    for (int s = first; s <= last; s++)
      if (hit_mask[s]) exp_q.push_back(slot_desc(s, row));
  endtask

  task automatic pulse_line_start(output int start_cnt);
    bus.LINE_START = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (cen_seen) break;
    end
    start_cnt = cen_cnt;
    bus.LINE_START = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int start_cnt, output int dur);
    for (int k = 0; k < 3000; k++) begin
      if (!bus.BUSY) break;
      tick();
    end
    if (bus.BUSY) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout: got BUSY=1 expected BUSY=0", name);
    end
    dur = cen_cnt - start_cnt;
  endtask

  task automatic wait_spr_a(input string name, input logic [7:0] a);
    for (int k = 0; k < 1000; k++) begin
      if (bus.BUSY && (bus.SPR_A == a)) break;
      tick();
    end
    if (!(bus.BUSY && (bus.SPR_A == a))) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout: got SPR_A=0x%0h expected 0x%0h", name, bus.SPR_A, a);
    end
  endtask

  initial begin
    int t0;
    int dur;
    logic [10:0] ph_exp [6];
    logic [63:0] mask;
    // {SPR_A, K_LD, K_H4, K_H8} over ADDR, YPH, DATPH, EVAL, NEXT, ADDR(slot 1)
    ph_exp[0] = {8'h00, 3'b100};
    ph_exp[1] = {8'h00, 3'b000};
    ph_exp[2] = {8'h00, 3'b010};
    ph_exp[3] = {8'h00, 3'b000};
    ph_exp[4] = {8'h00, 3'b100};
    ph_exp[5] = {8'h04, 3'b100};

    bus.LINE_START = 1'b0;
    bus.VCNT       = 8'h20;
    bus.HIT_READY  = 1'b1;
    load_mem(64'h0);
    repeat (3) tick();

    check("rst_spr_a", bus.SPR_A, 8'h00);
    check("rst_ob", bus.OB, 8'h00);
    check("rst_pins", {bus.K_LD, bus.K_H4, bus.K_H8}, 3'b100);
    check("rst_valid", bus.HIT_VALID, 1'b0);
    check("rst_fields", {bus.HIT_CODE, bus.HIT_ATTR, bus.HIT_X, bus.HIT_ROW}, 30'd0);
    check("rst_busy", bus.BUSY, 1'b0);
    check("rst_ovf", bus.OVERFLOW, 1'b0);
    rst_n = 1'b1;
    tick();

    // Single hit on slot 2: Y=0xD0, VCNT=0x20 -> row 0x30
    mask = 64'h4;
    load_mem(mask);
    push_range(0, NSPR - 1, mask, 6'h30);
    pulse_line_start(t0);
    for (int i = 0; i < 6; i++) begin
      if (i > 0) tick();
      check($sformatf("phase%0d", i), {bus.SPR_A, bus.K_LD, bus.K_H4, bus.K_H8}, ph_exp[i]);
    end
    wait_idle("single", t0, dur);
    check("single_busy_cen", dur, NSPR * 5 + 4);
    check("single_ovf", bus.OVERFLOW, 1'b0);
    repeat (4) tick();
    check("single_q_empty", exp_q.size(), 0);

    // All miss with CEN every other clock
    cen_mode = 1;
    load_mem(64'h0);
    pulse_line_start(t0);
    wait_idle("miss", t0, dur);
    check("miss_busy_cen", dur, NSPR * 5);
    check("miss_ovf", bus.OVERFLOW, 1'b0);
    check("miss_valid", bus.HIT_VALID, 1'b0);
    cen_mode = 0;
    repeat (4) tick();

    // Overflow: every slot hits, VCNT=0x25 -> row 0x35, stop at the ninth hit
    bus.VCNT = 8'h25;
    mask = 64'hFF_FFFF;
    load_mem(mask);
    push_range(0, MAXH - 1, mask, 6'h35);
    pulse_line_start(t0);
    wait_idle("ovf", t0, dur);
    check("ovf_flag", bus.OVERFLOW, 1'b1);
    check("ovf_busy_cen", dur, MAXH * 9 + 4);
    repeat (4) tick();
    check("ovf_q_empty", exp_q.size(), 0);

    // Backpressure: hits on slots 1, 3, 4, consumer stalls for 20 clocks
    bus.VCNT = 8'h20;
    mask = 64'h1A;
    load_mem(mask);
    push_range(0, NSPR - 1, mask, 6'h30);
    pulse_line_start(t0);
    for (int k = 0; k < 200; k++) begin
      if (bus.HIT_VALID) break;
      tick();
    end
    check("bp_first_valid", bus.HIT_VALID, 1'b1);
    bus.HIT_READY = 1'b0;
    repeat (20) tick();
    check("bp_valid_held", bus.HIT_VALID, 1'b1);
    check("bp_push_stall", bus.SPR_A, 8'h0F);
    bus.HIT_READY = 1'b1;
    wait_idle("bp", t0, dur);
    repeat (4) tick();
    check("bp_q_empty", exp_q.size(), 0);

    // Restart at slot 5: hit count must start over, so 8 more descriptors follow
    mask = 64'hFF_FFFF;
    load_mem(mask);
    push_range(0, 4, mask, 6'h30);
    pulse_line_start(t0);
    wait_spr_a("restart_wait", 8'h14);
    push_range(0, MAXH - 1, mask, 6'h30);
    pulse_line_start(t0);
    check("restart_spr_a", bus.SPR_A, 8'h00);
    check("restart_busy", bus.BUSY, 1'b1);
    check("restart_ovf", bus.OVERFLOW, 1'b0);
    wait_idle("restart", t0, dur);
    check("restart_ovf_end", bus.OVERFLOW, 1'b1);
    repeat (4) tick();
    check("restart_q_empty", exp_q.size(), 0);

    // Reset during slot 0 fetch, with CEN low on the reset edge
    mask = 64'h1;
    load_mem(mask);
    pulse_line_start(t0);
    wait_spr_a("reset_wait", 8'h02);
    cen_mode = 2;
    rst_n = 1'b0;
    tick();
    check("mrst_k_ld", bus.K_LD, 1'b1);
    check("mrst_valid", bus.HIT_VALID, 1'b0);
    check("mrst_busy", bus.BUSY, 1'b0);
    check("mrst_spr_a", bus.SPR_A, 8'h00);
    rst_n = 1'b1;
    cen_mode = 0;
    repeat (30) tick();
    check("mrst_idle", bus.BUSY, 1'b0);
    check("mrst_q_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
